// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter for NREQ single-beat requesters feeding one APB master port.
// Runs SETUP/ACCESS with a timeout, then a forced idle gap before the next grant.
module apb_req_arbiter #(
    parameter int NREQ     = 4,
    parameter int APB_ABIT = 16,
    parameter int APB_DBIT = 32,
    parameter int TIMEOUT  = 64,
    parameter int GAP_CYC  = 2
) (
    input  logic                     apb_clk,
    input  logic                     apb_rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*APB_ABIT-1:0] req_addr,
    input  logic [NREQ*APB_DBIT-1:0] req_wdata,
    input  logic [NREQ*4-1:0]        req_strb,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [APB_DBIT-1:0]      rsp_rdata,
    output logic                     rsp_err,
    output logic                     m_psel,
    output logic                     m_penable,
    output logic                     m_pwrite,
    output logic [APB_ABIT-1:0]      m_paddr,
    output logic [APB_DBIT-1:0]      m_pwdata,
    output logic [3:0]               m_pstrb,
    input  logic                     m_pready,
    input  logic [APB_DBIT-1:0]      m_prdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP_CYC);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    logic [1:0]          state;
    logic [IW-1:0]       last;
    logic [IW-1:0]       grant;
    logic [TW-1:0]       tmo_cnt;
    logic [GW-1:0]       gap_cnt;

    logic                win_valid;
    logic [IW-1:0]       win;
    logic [IW-1:0]       lo_win;
    logic [IW-1:0]       hi_win;
    logic                hi_any;
    logic                sel_write;
    logic [APB_ABIT-1:0] sel_addr;
    logic [APB_DBIT-1:0] sel_wdata;
    logic [3:0]          sel_strb;

    function automatic logic [NREQ-1:0] one_hot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner is the lowest requester above `last`, else the lowest overall (wrap).
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
        lo_win    = '0;
        hi_win    = '0;
        hi_any    = 1'b0;
        win_valid = |req_valid;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_win = IW'(i);
                if (i > int'(last)) begin
                    hi_win = IW'(i);
                    hi_any = 1'b1;
                end
            end
        end
        win = hi_any ? hi_win : lo_win;
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*APB_ABIT +: APB_ABIT];
                sel_wdata = req_wdata[i*APB_DBIT +: APB_DBIT];
                sel_strb  = req_strb[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge apb_clk or negedge apb_rstn) begin
        if (!apb_rstn) begin
            state     <= ST_IDLE;
            last      <= IW'(NREQ - 1);
            grant     <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            m_pstrb   <= '0;
        end else begin
            // NOTE: state updates are non-blocking so every register samples pre-edge values.
            req_ack   <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        grant     <= win;
                        last      <= win;
                        m_pwrite  <= sel_write;
                        m_paddr   <= sel_addr;
                        m_pwdata  <= sel_write ? sel_wdata : '0;
                        m_pstrb   <= sel_write ? sel_strb : 4'h0;
                        m_psel    <= 1'b1;
                        req_ack   <= one_hot(win);
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over a timeout landing in the same cycle.
                    if (m_pready || tmo_cnt == TW'(TIMEOUT - 1)) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        rsp_valid <= one_hot(grant);
                        rsp_err   <= ~m_pready;
                        rsp_rdata <= (m_pready && !m_pwrite) ? m_prdata : '0;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model of grant order and APB transfer outcome.
module tb_apb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int ABIT    = 16;
    localparam int DBIT    = 32;
    localparam int TIMEOUT = 64;
    localparam int GAP_CYC = 2;
    localparam int OW      = 2*NREQ + DBIT + 1 + 3 + ABIT + DBIT + 4;

    logic                 apb_clk = 1'b0;
    logic                 apb_rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*ABIT-1:0] req_addr = '0;
    logic [NREQ*DBIT-1:0] req_wdata = '0;
    logic [NREQ*4-1:0]    req_strb = '0;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      rsp_valid;
    logic [DBIT-1:0]      rsp_rdata;
    logic                 rsp_err;
    logic                 m_psel, m_penable, m_pwrite;
    logic [ABIT-1:0]      m_paddr;
    logic [DBIT-1:0]      m_pwdata;
    logic [3:0]           m_pstrb;
    logic                 m_pready = 1'b0;
    logic [DBIT-1:0]      m_prdata = '0;

    apb_req_arbiter #(
        .NREQ(NREQ), .APB_ABIT(ABIT), .APB_DBIT(DBIT), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
    ) dut (
        .apb_clk(apb_clk), .apb_rstn(apb_rstn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
        .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pready(m_pready), .m_prdata(m_prdata)
    );

    always #5 apb_clk = ~apb_clk;

    int cyc = 0;
    always @(posedge apb_clk) cyc <= cyc + 1;

    logic [OW-1:0] all_out;
    assign all_out = {req_ack, rsp_valid, rsp_rdata, rsp_err, m_psel, m_penable, m_pwrite,
                      m_paddr, m_pwdata, m_pstrb};

    typedef struct packed {
        logic            done;
        logic [NREQ-1:0] ack;
        logic [7:0]      ack_cycles;
        logic            stable;
        logic [7:0]      access;
        logic            write;
        logic [ABIT-1:0] addr;
        logic [DBIT-1:0] wdata;
        logic [3:0]      strb;
        logic [NREQ-1:0] rsp;
        logic            err;
        logic [DBIT-1:0] rdata;
        logic            rsp_bus_idle;
    } xfer_t;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_last   = NREQ - 1;

    logic            r_write [NREQ];
    logic [ABIT-1:0] r_addr  [NREQ];
    logic [DBIT-1:0] r_wdata [NREQ];
    logic [3:0]      r_strb  [NREQ];

    task automatic step();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic load_req(input int i, input logic w, input logic [ABIT-1:0] a,
                            input logic [DBIT-1:0] d, input logic [3:0] s);
        r_write[i] = w;
        r_addr[i]  = a;
        r_wdata[i] = d;
        r_strb[i]  = s;
        req_write[i]               = w;
        req_addr[i*ABIT +: ABIT]   = a;
        req_wdata[i*DBIT +: DBIT]  = d;
        req_strb[i*4 +: 4]         = s;
        req_valid[i]               = 1'b1;
    endtask

    // Grant rule: first pending requester in the order last+1, last+2, ... (mod NREQ).
    function automatic int model_pick(input logic [NREQ-1:0] mask);
        int order[$];
        for (int k = 1; k <= NREQ; k++) order.push_back((model_last + k) % NREQ);
        foreach (order[j]) begin
            if (mask[order[j]]) begin
                model_last = order[j];
                return order[j];
            end
        end
        return -1;
    endfunction

    // Expected outcome of one transfer; ready_after = ACCESS cycle carrying pready, 0 = never.
    function automatic xfer_t model_xfer(input int id, input int ready_after, input logic [DBIT-1:0] sd);
        xfer_t e;
        logic  to;
        to             = !(ready_after >= 1 && ready_after <= TIMEOUT);
        e              = '0;
        e.done         = 1'b1;
        e.ack[id]      = 1'b1;
        e.ack_cycles   = 8'd1;
        e.stable       = 1'b1;
        e.access       = to ? 8'(TIMEOUT) : 8'(ready_after);
        e.write        = r_write[id];
        e.addr         = r_addr[id];
        e.wdata        = r_write[id] ? r_wdata[id] : '0;
        e.strb         = r_write[id] ? r_strb[id] : 4'h0;
        e.rsp[id]      = 1'b1;
        e.err          = to;
        e.rdata        = (!r_write[id] && !to) ? sd : '0;
        e.rsp_bus_idle = 1'b1;
        return e;
    endfunction

    function automatic string fmt(input xfer_t x);
        return $sformatf("done=%b ack=%b/%0d stable=%b acc=%0d w=%b a=%h d=%h s=%h rsp=%b err=%b rd=%h idle=%b",
                         x.done, x.ack, x.ack_cycles, x.stable, x.access, x.write, x.addr, x.wdata,
                         x.strb, x.rsp, x.err, x.rdata, x.rsp_bus_idle);
    endfunction

    // Acts as the APB slave and records what the DUT did for one transfer.
    task automatic run_xfer(input int ready_after, input logic [DBIT-1:0] sd, input logic idle_ready,
                            input logic [NREQ-1:0] keep, output xfer_t o,
                            output int setup_at, output int rsp_at);
        int acc;
        acc      = 0;
        o        = '0;
        o.stable = 1'b1;
        setup_at = -1;
        rsp_at   = -1;
        m_pready = idle_ready;
        m_prdata = sd;
        for (int c = 0; c < 400; c++) begin
            step();
            if (req_ack != '0) begin
                o.ack_cycles = o.ack_cycles + 8'd1;
                if (setup_at < 0) begin
                    setup_at = cyc;
                    o.ack    = req_ack;
                    o.write  = m_pwrite;
                    o.addr   = m_paddr;
                    o.wdata  = m_pwdata;
                    o.strb   = m_pstrb;
                    if (!(m_psel && !m_penable)) o.stable = 1'b0;
                end
                req_valid = req_valid & ~(req_ack & ~keep);
            end
            if (m_psel && m_penable) begin
                acc++;
                if (m_pwrite !== o.write || m_paddr !== o.addr || m_pwdata !== o.wdata || m_pstrb !== o.strb)
                    o.stable = 1'b0;
                m_pready = (acc == ready_after);
            end else begin
                m_pready = idle_ready;
            end
            if (rsp_valid != '0) begin
                o.done         = 1'b1;
                o.rsp          = rsp_valid;
                o.err          = rsp_err;
                o.rdata        = rsp_rdata;
                o.rsp_bus_idle = !m_psel && !m_penable;
                o.access       = 8'(acc);
                rsp_at         = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apb_rstn  = 1'b0;
        req_valid = '0;
        m_pready  = 1'b0;
        repeat (3) step();
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        apb_rstn   = 1'b1;
        model_last = NREQ - 1;
        repeat (4) step();
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h want 0", all_out);
        end
    endtask

    task automatic test_single_write();
        xfer_t o, e;
        int    s, r;
        load_req(2, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        e = model_xfer(model_pick(req_valid), 3, 32'h0BAD_F00D);
        run_xfer(3, 32'h0BAD_F00D, 1'b0, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL single_write: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_single_read();
        xfer_t o, e;
        int    s, r;
        load_req(0, 1'b0, 16'h0024, 32'hCAFEF00D, 4'hF);
        e = model_xfer(model_pick(req_valid), 1, 32'h12345678);
        run_xfer(1, 32'h12345678, 1'b0, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL single_read: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_round_robin();
        xfer_t o, e;
        int    s, r, prev_s, prev_r;
        apb_rstn = 1'b0;
        #2;
        for (int i = 0; i < NREQ; i++)
            load_req(i, i[0], 16'(16'h0100 + i*4), 32'h1000_0000 + i, 4'(i + 3));
        step();
        apb_rstn   = 1'b1;
        model_last = NREQ - 1;
        prev_s     = -1;
        prev_r     = -1;
        for (int n = 0; n < NREQ + 1; n++) begin
            e = model_xfer(model_pick(req_valid), 1, 32'h7700_0000 + n);
            run_xfer(1, 32'h7700_0000 + n, 1'b0, '1, o, s, r);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got %s want %s", n, fmt(o), fmt(e));
            end
            if (prev_s >= 0) begin
                tests_run++;
                if (s - prev_s < 3 + GAP_CYC || s - prev_r != GAP_CYC + 1) begin
                    tests_failed++;
                    $display("FAIL rr_spacing_%0d: got setup-setup=%0d rsp-setup=%0d want >=%0d and %0d",
                             n, s - prev_s, s - prev_r, 3 + GAP_CYC, GAP_CYC + 1);
                end
            end
            prev_s = s;
            prev_r = r;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        xfer_t o, e;
        int    s, r;
        load_req(1, 1'b0, 16'h0200, 32'h0, 4'hF);
        e = model_xfer(model_pick(req_valid), 0, 32'hA5A5A5A5);
        run_xfer(0, 32'hA5A5A5A5, 1'b0, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL timeout_abort: got %s want %s", fmt(o), fmt(e));
        end
        load_req(3, 1'b0, 16'h0204, 32'h0, 4'h3);
        e = model_xfer(model_pick(req_valid), TIMEOUT, 32'h5A5A5A5A);
        run_xfer(TIMEOUT, 32'h5A5A5A5A, 1'b0, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL timeout_tie_pready: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_spurious_pready();
        xfer_t o, e;
        int    s, r;
        logic  bad;
        req_valid = '0;
        m_pready  = 1'b1;
        repeat (GAP_CYC + 2) step();
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (m_psel || m_penable || req_ack != '0 || rsp_valid != '0) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_idle: got activity=%b want 0", bad);
        end
        load_req(1, 1'b0, 16'h0300, 32'h0, 4'hF);
        e = model_xfer(model_pick(req_valid), 2, 32'h0000_BEEF);
        run_xfer(2, 32'h0000_BEEF, 1'b1, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL spurious_setup_ignored: got %s want %s", fmt(o), fmt(e));
        end
        load_req(3, 1'b1, 16'h0304, 32'h1111_2222, 4'h5);
        e = model_xfer(model_pick(req_valid), 1, 32'h3333_4444);
        run_xfer(1, 32'h3333_4444, 1'b1, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL spurious_then_fast: got %s want %s", fmt(o), fmt(e));
        end
        m_pready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        xfer_t o, e;
        int    s, r, acc;
        logic  bad;
        req_valid = '0;
        m_pready  = 1'b0;
        load_req(2, 1'b1, 16'h0400, 32'h4444_0000, 4'hC);
        acc = 0;
        for (int c = 0; c < 80 && acc < 3; c++) begin
            step();
            if (req_ack != '0) req_valid = '0;
            if (m_psel && m_penable) acc++;
        end
        tests_run++;
        if (acc != 3) begin
            tests_failed++;
            $display("FAIL reset_mid_reach_access: got %0d access cycles want 3", acc);
        end
        #2;
        apb_rstn = 1'b0;
        #1;
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_async_clear: got %h want 0", all_out);
        end
        for (int i = 0; i < NREQ; i++)
            load_req(i, 1'b0, 16'(16'h0500 + i), 32'h0, 4'hF);
        bad = 1'b0;
        repeat (2) begin
            step();
            if (all_out !== '0) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_held: got activity=%b want 0", bad);
        end
        apb_rstn   = 1'b1;
        model_last = NREQ - 1;
        e = model_xfer(model_pick(req_valid), 1, 32'h0102_0304);
        run_xfer(1, 32'h0102_0304, 1'b0, '0, o, s, r);
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got %s want %s", fmt(o), fmt(e));
        end
        req_valid = '0;
    endtask

    task automatic new_req(input int i);
        load_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic test_random();
        xfer_t o, e;
        int    s, r, prev_r, id, ra;
        logic [DBIT-1:0] sd;
        prev_r = -1;
        for (int n = 0; n < 40; n++) begin
            if (req_valid == '0) new_req($urandom_range(0, NREQ - 1));
            id = model_pick(req_valid);
            ra = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            sd = $urandom;
            e  = model_xfer(id, ra, sd);
            run_xfer(ra, sd, 1'($urandom_range(0, 1)), '0, o, s, r);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL random_%0d: got %s want %s", n, fmt(o), fmt(e));
            end
            if (prev_r >= 0) begin
                tests_run++;
                if (s - prev_r != GAP_CYC + 1) begin
                    tests_failed++;
                    $display("FAIL random_gap_%0d: got rsp-setup=%0d want %0d", n, s - prev_r, GAP_CYC + 1);
                end
            end
            prev_r = r;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) new_req(i);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        m_pready  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_spurious_pready();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
